// File: rtl/instr_encoder_loader.sv
// Streaming RV32I encoder: re-packs decoded instruction fields into 32-bit words
// and writes them to consecutive instruction-memory addresses over a ready/valid port.
`timescale 1ns/1ps
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              last_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        fn3_i,
    input  logic [11:0]       imm_i,
    input  logic [19:0]       imm_uj_i,
    input  logic              fn7_5_i,
    input  logic [6:0]        imm11_5_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic [1:0]        err_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   acc_q, acc_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_q, err_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [31:0]       wrData_q, wrData_d;

    logic [31:0] encWord;
    logic        encBad;
    logic        accept;
    logic        wrDone;
    logic        unusedImm;

    // Shift immediates come from imm[11:5], so the separate imm11_5 field carries nothing.
    assign unusedImm = ^imm11_5_i;

    always_comb begin
        encWord = 32'h0000_0013;
        encBad  = 1'b0;
        case (opcode_i)
            OP_R:                     encWord = {1'b0, fn7_5_i, 5'b0, rs2_i, rs1_i, fn3_i, rd_i, opcode_i};
            OP_IMM, OP_LOAD, OP_JALR: encWord = {imm_i, rs1_i, fn3_i, rd_i, opcode_i};
            OP_STORE:                 encWord = {imm_i[11:5], rs2_i, rs1_i, fn3_i, imm_i[4:0], opcode_i};
            OP_BRANCH:                encWord = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, fn3_i,
                                                 imm_i[3:0], imm_i[10], opcode_i};
            OP_JAL:                   encWord = {imm_uj_i[19], imm_uj_i[9:0], imm_uj_i[10],
                                                 imm_uj_i[18:11], rd_i, opcode_i};
            OP_LUI, OP_AUIPC:         encWord = {imm_uj_i, rd_i, opcode_i};
            default:                  encBad  = 1'b1;
        endcase
    end

    assign wrDone     = wrEn_q && wr_ready_i;
    assign in_ready_o = (state_q == S_RUN) && (!wrEn_q || wr_ready_i) && (acc_q < DEPTH_C);
    assign accept     = in_valid_i && in_ready_o;

    // A completing write and a fresh accept can share a cycle; the accept wins wr_en.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        err_d    = err_q;
        wrEn_d   = wrEn_q;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;

        if (wrDone) begin
            wrEn_d  = 1'b0;
            count_d = count_q + ONE_C;
        end
        if (accept) begin
            wrEn_d   = 1'b1;
            wrAddr_d = BASE_C + acc_q[ADDR_W-1:0];
            wrData_d = encWord;
            acc_d    = acc_q + ONE_C;
            if (encBad) begin
                err_d[0] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    count_d = '0;
                    err_d   = '0;
                end
            end
            S_RUN: begin
                if (accept && (last_i || (acc_q + ONE_C == DEPTH_C))) begin
                    state_d = S_DRAIN;
                    if (!last_i) begin
                        err_d[1] = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!wrEn_q || wr_ready_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            err_q    <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= BASE_C;
            wrData_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            err_q    <= err_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
        end
    end

    assign wr_en_o   = wrEn_q;
    assign wr_addr_o = wrAddr_q;
    assign wr_data_o = wrData_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign count_o   = count_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised self-checking bench for instr_encoder_loader against a field-arithmetic
// encoder model and an expected-write queue.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 3;
    localparam int DEPTH     = 8;
    localparam int BASE_ADDR = 5;

    typedef struct {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fn3;
        logic [11:0] imm;
        logic [19:0] immUj;
        logic        fn75;
        logic [6:0]  imm115;
    } tuple_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } expWrite_t;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              last_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        fn3_i;
    logic [11:0]       imm_i;
    logic [19:0]       imm_uj_i;
    logic              fn7_5_i;
    logic [6:0]        imm11_5_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              wr_ready_i;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W:0]   count_o;
    logic [1:0]        err_o;

    int        checks = 0;
    int        errors = 0;
    expWrite_t expQ[$];
    int        nAcc = 0;
    int        compCount = 0;
    int        doneCount = 0;
    int        cyc = 0;
    int        stallCycles = 0;
    bit        randStall = 0;
    bit        prevCompleted = 0;
    logic [1:0] expErr = 2'b00;

    logic [6:0] supported [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

    instr_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .last_i    (last_i),
        .opcode_i  (opcode_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .fn3_i     (fn3_i),
        .imm_i     (imm_i),
        .imm_uj_i  (imm_uj_i),
        .fn7_5_i   (fn7_5_i),
        .imm11_5_i (imm11_5_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .wr_ready_i(wr_ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic bit refSupported(input logic [6:0] op);
        bit hit = 0;
        foreach (supported[i]) if (supported[i] == op) hit = 1;
        return hit;
    endfunction

    // Reference encoding built from field positions with shifts and masks.
    function automatic logic [31:0] refEncode(input tuple_t t);
        int unsigned op  = t.opcode;
        int unsigned rd  = t.rd;
        int unsigned r1  = t.rs1;
        int unsigned r2  = t.rs2;
        int unsigned f3  = t.fn3;
        int unsigned im  = t.imm;
        int unsigned u   = t.immUj;
        int unsigned f75 = t.fn75;
        int unsigned w;
        case (t.opcode)
            7'h33:               w = (f75 << 30) + (r2 << 20) + (r1 << 15) + (f3 << 12) + (rd << 7) + op;
            7'h13, 7'h03, 7'h67: w = (im << 20) + (r1 << 15) + (f3 << 12) + (rd << 7) + op;
            7'h23:               w = ((im >> 5) << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12)
                                     + ((im & 31) << 7) + op;
            7'h63:               w = (((im >> 11) & 1) << 31) + (((im >> 4) & 63) << 25) + (r2 << 20)
                                     + (r1 << 15) + (f3 << 12) + ((im & 15) << 8)
                                     + (((im >> 10) & 1) << 7) + op;
            7'h6F:               w = (((u >> 19) & 1) << 31) + ((u & 1023) << 21) + (((u >> 10) & 1) << 20)
                                     + (((u >> 11) & 255) << 12) + (rd << 7) + op;
            7'h37, 7'h17:        w = (u << 12) + (rd << 7) + op;
            default:             w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    function automatic tuple_t randTuple(input bit allowBad);
        tuple_t t;
        t.opcode = supported[$urandom_range(0, 8)];
        t.rd     = 5'($urandom);
        t.rs1    = 5'($urandom);
        t.rs2    = 5'($urandom);
        t.fn3    = 3'($urandom);
        t.imm    = 12'($urandom);
        t.immUj  = 20'($urandom);
        t.fn75   = 1'($urandom);
        t.imm115 = 7'($urandom);
        if (allowBad && $urandom_range(0, 5) == 0) begin
            t.opcode = 7'($urandom);
            if (refSupported(t.opcode)) t.opcode = 7'b1110011;
        end
        return t;
    endfunction

    function automatic tuple_t goldTuple(input int idx);
        tuple_t t = randTuple(0);
        case (idx)
            0: begin t.opcode = 7'h13; t.rd = 1; t.rs1 = 0; t.fn3 = 0; t.imm = 12'd5; end
            1: begin t.opcode = 7'h33; t.rd = 3; t.rs1 = 1; t.rs2 = 2; t.fn3 = 0; t.fn75 = 0; end
            2: begin t.opcode = 7'h33; t.rd = 3; t.rs1 = 1; t.rs2 = 2; t.fn3 = 0; t.fn75 = 1; end
            3: begin t.opcode = 7'h23; t.rs1 = 1; t.rs2 = 2; t.fn3 = 3'd2; t.imm = 12'd8; end
            4: begin t.opcode = 7'h37; t.rd = 5; t.immUj = 20'h12345; end
            default: begin t.opcode = 7'h6F; t.rd = 1; t.immUj = 20'h00004; end
        endcase
        return t;
    endfunction

    // Memory-side ready: forced stalls first, then optional random backpressure.
    initial begin
        wr_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stallCycles > 0) begin
                wr_ready_i = 1'b0;
                stallCycles--;
            end else if (randStall) begin
                wr_ready_i = ($urandom_range(0, 2) != 0);
            end else begin
                wr_ready_i = 1'b1;
            end
        end
    end

    // Write monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            doneCount++;
            checkOutput("doneAfterLastWrite", 32'(prevCompleted), 32'd1);
            checkOutput("doneAllWritten", 32'(compCount), 32'(nAcc));
        end
        prevCompleted = 0;
        if (rst_n && wr_en_o) begin
            checkOutput("writeExpected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                checkOutput("wrAddr", 32'(wr_addr_o), expQ[0].addr);
                checkOutput("wrData", wr_data_o, expQ[0].data);
                if (wr_ready_i) begin
                    void'(expQ.pop_front());
                    compCount++;
                    prevCompleted = 1;
                end else begin
                    checkOutput("inReadyDuringStall", 32'(in_ready_o), 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input tuple_t t, input logic isLast, input logic [31:0] expWord,
                                 input int budget, output bit ok);
        ok         = 0;
        opcode_i   = t.opcode;
        rd_i       = t.rd;
        rs1_i      = t.rs1;
        rs2_i      = t.rs2;
        fn3_i      = t.fn3;
        imm_i      = t.imm;
        imm_uj_i   = t.immUj;
        fn7_5_i    = t.fn75;
        imm11_5_i  = t.imm115;
        last_i     = isLast;
        in_valid_i = 1'b1;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = in_ready_o;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        last_i     = 1'b0;
        if (ok) begin
            expQ.push_back('{addr: 32'((BASE_ADDR + nAcc) % (1 << ADDR_W)), data: expWord});
            nAcc++;
            if (!refSupported(t.opcode)) expErr[0] = 1'b1;
        end
    endtask

    task automatic sendTuple(input tuple_t t, input logic isLast);
        bit ok;
        applyStimulus(t, isLast, refEncode(t), 30, ok);
        checkOutput("tupleAccepted", 32'(ok), 32'd1);
    endtask

    task automatic startSession();
        expQ.delete();
        nAcc      = 0;
        compCount = 0;
        doneCount = 0;
        expErr    = 2'b00;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
    endtask

    task automatic finishSession(input int expCount, input logic [1:0] expErrV);
        int c = 0;
        while (busy_o && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("sessionEnded", 32'(busy_o), 32'd0);
        checkOutput("donePulses", 32'(doneCount), 32'd1);
        checkOutput("count", 32'(count_o), 32'(expCount));
        checkOutput("writesCompleted", 32'(compCount), 32'(expCount));
        checkOutput("err", 32'(err_o), 32'(expErrV));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".inReady"}, 32'(in_ready_o), 32'd0);
        checkOutput({tag, ".wrEn"},    32'(wr_en_o),    32'd0);
        checkOutput({tag, ".wrAddr"},  32'(wr_addr_o),  32'(BASE_ADDR));
        checkOutput({tag, ".wrData"},  wr_data_o,       32'd0);
        checkOutput({tag, ".busy"},    32'(busy_o),     32'd0);
        checkOutput({tag, ".done"},    32'(done_o),     32'd0);
        checkOutput({tag, ".count"},   32'(count_o),    32'd0);
        checkOutput({tag, ".err"},     32'(err_o),      32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] gold [6] = '{32'h00500093, 32'h002081B3, 32'h402081B3,
                                  32'h0020A423, 32'h123452B7, 32'h008000EF};
        bit ok;
        int c0;
        int n;
        tuple_t t;

        rst_n = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; last_i = 1'b0;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; fn3_i = '0;
        imm_i = '0; imm_uj_i = '0; fn7_5_i = 1'b0; imm11_5_i = '0;
        #3 rst_n = 1'b0;
        #10;
        checkResetValues("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] round-trip program");
        startSession();
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(goldTuple(i), (i == 5), gold[i], 30, ok);
            checkOutput("rtAccepted", 32'(ok), 32'd1);
        end
        checkOutput("rtThroughput", 32'(cyc - c0), 32'd6);
        finishSession(6, 2'b00);

        $display("[TB] backpressure");
        startSession();
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b0);
        stallCycles = 3;
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b1);
        finishSession(5, 2'b00);

        $display("[TB] unsupported opcode");
        startSession();
        sendTuple(goldTuple(0), 1'b0);
        t = randTuple(0);
        t.opcode = 7'b1110011;
        applyStimulus(t, 1'b0, 32'h0000_0013, 30, ok);
        checkOutput("badAccepted", 32'(ok), 32'd1);
        checkOutput("badErrSet", 32'(err_o), 32'd1);
        sendTuple(randTuple(0), 1'b1);
        finishSession(3, 2'b01);
        checkOutput("badErrStickyIdle", 32'(err_o), 32'd1);

        $display("[TB] start pulsed during RUN");
        startSession();
        checkOutput("startClearsErr", 32'(err_o), 32'd0);
        sendTuple(t, 1'b0);
        sendTuple(randTuple(0), 1'b0);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        checkOutput("startInRunCount", 32'(count_o), 32'(compCount));
        checkOutput("startInRunErr", 32'(err_o), 32'd1);
        checkOutput("startInRunBusy", 32'(busy_o), 32'd1);
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b1);
        finishSession(4, 2'b01);

        $display("[TB] overflow without last");
        startSession();
        for (int i = 0; i < DEPTH + 2; i++) begin
            t = randTuple(0);
            applyStimulus(t, 1'b0, refEncode(t), 4, ok);
            checkOutput("ovfAccept", 32'(ok), 32'(i < DEPTH));
            if (i == DEPTH - 1) begin
                @(negedge clk);
                checkOutput("ovfInReadyLow", 32'(in_ready_o), 32'd0);
                @(posedge clk); #1;
            end
        end
        finishSession(DEPTH, 2'b10);

        $display("[TB] reset mid-session");
        startSession();
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        startSession();
        checkOutput("countRestart", 32'(count_o), 32'd0);
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b0);
        sendTuple(randTuple(0), 1'b1);
        finishSession(3, 2'b00);

        $display("[TB] random sessions with random backpressure");
        randStall = 1;
        for (int s = 0; s < 4; s++) begin
            startSession();
            n = $urandom_range(3, DEPTH);
            for (int i = 0; i < n; i++) begin
                sendTuple(randTuple(1), (i == n - 1));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            finishSession(n, expErr);
        end
        randStall = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming RISC-V instruction encoder and instruction-memory loader for the single-cycle core's bring-up path. It accepts decoded instruction fields in the same packing the core's decoder produces and re-assembles each into a 32-bit RV32I word. It writes each word into instruction memory at consecutive word addresses through a ready/valid write port. Program loading is bracketed by a start pulse and a `last`-tagged final instruction.

## Interface
- ADDR_W, 8: width of instruction-memory word address.
- DEPTH, 256: max words per program; must satisfy DEPTH ≤ 2^ADDR_W.
- BASE_ADDR, 0: word address of the first write.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a load session; honoured only in IDLE.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple this cycle.
- last  in  1  tuple is final instruction of program.
- opcode  in  7 · rd, rs1, rs2  in  5 each · fn3  in  3 · imm  in  12 · imm_uj  in  20 · fn7_5  in  1 · imm11_5  in  7 (ignored; I-type shifts take bits 31:25 from imm[11:5]).
- wr_en  out  1  write request to instruction memory.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- wr_ready  in  1  memory accepts the write when wr_en && wr_ready.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at session end.
- count  out  ADDR_W+1  completed writes this session.
- err  out  2  sticky; bit0 unsupported opcode, bit1 overflow (DEPTH reached without last).

## Operation
- States: IDLE → RUN on start. RUN → DRAIN when a tuple with last=1 is accepted, or when the accepted count reaches DEPTH. DRAIN → DONE when the pending write completes. DONE → IDLE unconditionally after one cycle, with done=1 in DONE.
- start clears count, the accept counter, and err. start outside IDLE is ignored.
- in_ready = (state==RUN) && (!wr_en || wr_ready) && (accepted < DEPTH).
- Accept (in_valid && in_ready) registers wr_data, sets wr_addr = BASE_ADDR + accepted (mod 2^ADDR_W), sets wr_en=1, and increments accepted.
- wr_en, wr_addr, and wr_data hold stable until wr_ready. A completing write with no new accept clears wr_en. A completing write together with a new accept in the same cycle keeps wr_en high and loads the new word.
- count increments on each completed write.
- Overflow: if accepted reaches DEPTH with last never seen, set err[1] when entering DRAIN.
- Encoding (each case is the exact inverse of the decoder field packing):
  - R 0110011: {1'b0, fn7_5, 5'b0, rs2, rs1, fn3, rd, op}.
  - I 0010011, load 0000011, JALR 1100111: {imm, rs1, fn3, rd, op}.
  - Store 0100011: {imm[11:5], rs2, rs1, fn3, imm[4:0], op}.
  - Branch 1100011: {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], op}.
  - JAL 1101111: {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, op}.
  - LUI 0110111, AUIPC 0010111: {imm_uj, rd, op}.
  - Any other opcode: write 32'h00000013 (NOP) and set err[0]. The write still consumes an address.
- Fields not used by a format are ignored.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr BASE_ADDR, wr_data 0, busy 0, done 0, count 0, err 0.
- Latency: a tuple accepted at edge N gives wr_en=1 with its data from edge N (visible in cycle N+1).
- Throughput is one instruction per cycle while wr_ready=1.
- wr_ready low stalls the pipe. in_ready drops the same cycle combinationally; no tuple is lost or duplicated.
- done is asserted exactly one cycle after the last write completes. busy deasserts the following cycle.
- Reset mid-session aborts immediately to reset values. A pending write is dropped.
- wr_addr wraps modulo 2^ADDR_W when BASE_ADDR + DEPTH exceeds 2^ADDR_W.

## Test plan
- Round-trip: start, then send addi x1,x0,5; add x3,x1,x2; sub x3,x1,x2 (fn7_5=1); sw x2,8(x1); lui x5,0x12345; jal x1 with imm_uj=20'h00004 (last). Required: wr_data 0x00500093, 0x002081B3, 0x402081B3, 0x0020A423, 0x123452B7, 0x008000EF at addresses 0..5; done pulses once; count=6; err=0.
- Backpressure: hold wr_ready=0 for 3 cycles mid-stream. Required: wr_en/wr_addr/wr_data stable, in_ready=0 throughout, no drop or duplicate, final count correct.
- Bad opcode 7'b1110011. Required: wr_data 0x00000013, err[0]=1 until the next start, address still advances.
- Overflow with DEPTH=4 and 6 tuples offered, none marked last. Required: exactly 4 writes, in_ready low after the 4th accept, err[1]=1, done pulse.
- rst_n low during the 3rd of 5 writes. Required: all outputs return to reset values asynchronously. A new start then writes from BASE_ADDR with count restarted at 0.
- start pulsed while in RUN. Required: no effect on count, address, or err.
